// File: rtl/run_controller_if.sv
// Launch/readout bundle between the run controller and the host + core side.
interface run_controller_if #(
  parameter int unsigned DM_AW = 8,
  parameter int unsigned RF_AW = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 32
);
  logic             go;
  logic             start;
  logic             halt;
  logic             dm_we;
  logic [DM_AW-1:0] dm_addr;
  logic [DW-1:0]    dm_wdata;
  logic             rf_we;
  logic [RF_AW-1:0] rf_addr;
  logic [DW-1:0]    rf_wdata;
  logic [DW-1:0]    rf_rdata;
  logic             dump_valid;
  logic             dump_ready;
  logic [RF_AW-1:0] dump_idx;
  logic [DW-1:0]    dump_data;
  logic [CNT_W-1:0] cycle_count;
  logic             busy;
  logic             done;
  logic             timeout;

  // Controller side
  modport master (
    input  go, halt, rf_rdata, dump_ready,
    output start, dm_we, dm_addr, dm_wdata, rf_we, rf_addr, rf_wdata,
           dump_valid, dump_idx, dump_data, cycle_count, busy, done, timeout
  );

  // Host / core / memories side
  modport slave (
    output go, halt, rf_rdata, dump_ready,
    input  start, dm_we, dm_addr, dm_wdata, rf_we, rf_addr, rf_wdata,
           dump_valid, dump_idx, dump_data, cycle_count, busy, done, timeout
  );
endinterface

// File: rtl/run_controller.sv
// Host-side run controller: clears memories, launches the core, times the run,
// then streams the register file out over a valid/ready port.
module run_controller #(
  parameter int unsigned DM_DEPTH     = 256,
  parameter int unsigned RF_DEPTH     = 8,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 1000000,
  parameter int unsigned CNT_W        = 32
) (
  input logic              CLK,
  input logic              reset,
  run_controller_if.master bus
);

  localparam int unsigned DM_AW   = $clog2(DM_DEPTH);
  localparam int unsigned RF_AW   = $clog2(RF_DEPTH);
  localparam int unsigned DW      = 8;
  localparam int unsigned MAX_DR  = (DM_DEPTH > RF_DEPTH) ? DM_DEPTH : RF_DEPTH;
  localparam int unsigned MAX_ALL = (MAX_DR > START_CYCLES) ? MAX_DR : START_CYCLES;
  localparam int unsigned IDX_W   = $clog2(MAX_ALL + 1);
  // A zero launch length still spends one cycle in LAUNCH.
  localparam int unsigned LAUNCH_LAST = (START_CYCLES == 0) ? 0 : START_CYCLES - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR_MEM, S_CLEAR_REG, S_LAUNCH, S_RUN, S_DUMP, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               timeout_q, timeout_d;

  logic               start_q, start_d;
  logic               dm_we_q, dm_we_d;
  logic [DM_AW-1:0]   dm_addr_q, dm_addr_d;
  logic               rf_we_q, rf_we_d;
  logic [RF_AW-1:0]   rf_addr_q, rf_addr_d;
  logic               dump_valid_q, dump_valid_d;
  logic [RF_AW-1:0]   dump_idx_q, dump_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State, shared index counter, run cycle counter and sticky timeout flag
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register cleanly
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.go) begin
          state_d       = S_CLEAR_MEM;
          idx_d         = '0;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
        end
      end
      S_CLEAR_MEM: begin
        if (idx_q == IDX_W'(DM_DEPTH - 1)) begin
          state_d = S_CLEAR_REG;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_CLEAR_REG: begin
        if (idx_q == IDX_W'(RF_DEPTH - 1)) begin
          state_d = S_LAUNCH;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_LAUNCH: begin
        if (idx_q == IDX_W'(LAUNCH_LAST)) begin
          state_d = S_RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_RUN: begin
        // halt has priority over a coincident timeout
        if (bus.halt) begin
          state_d = S_DUMP;
        end else if ((TIMEOUT != 0) && (cycle_count_q == CNT_W'(TIMEOUT))) begin
          state_d   = S_DUMP;
          timeout_d = 1'b1;
        end else if (cycle_count_q != {CNT_W{1'b1}}) begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end
      end
      S_DUMP: begin
        if (bus.dump_ready) begin
          if (idx_q == IDX_W'(RF_DEPTH - 1)) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    start_d      = (state_d != S_RUN);
    dm_we_d      = (state_d == S_CLEAR_MEM);
    dm_addr_d    = dm_we_d ? DM_AW'(idx_d) : '0;
    rf_we_d      = (state_d == S_CLEAR_REG);
    dump_valid_d = (state_d == S_DUMP);
    rf_addr_d    = (rf_we_d || dump_valid_d) ? RF_AW'(idx_d) : '0;
    dump_idx_d   = dump_valid_d ? RF_AW'(idx_d) : '0;
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
  end

  // Registered interface outputs; start comes out of reset holding the core
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      start_q      <= 1'b1;
      dm_we_q      <= 1'b0;
      dm_addr_q    <= '0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      start_q      <= start_d;
      dm_we_q      <= dm_we_d;
      dm_addr_q    <= dm_addr_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.start       = start_q;
  assign bus.dm_we       = dm_we_q;
  assign bus.dm_addr     = dm_addr_q;
  assign bus.dm_wdata    = '0;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_wdata    = '0;
  assign bus.dump_valid  = dump_valid_q;
  assign bus.dump_idx    = dump_idx_q;
  // Register file read is combinational, so the beat data is passed straight through
  assign bus.dump_data   = dump_valid_q ? bus.rf_rdata : DW'(0);
  assign bus.cycle_count = cycle_count_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: memory/core stubs, table-driven runs, random runs
// against a run-outcome model, and reset/busy corner sequences.
module tb_run_controller;

  localparam int unsigned TMO = 100;

  logic CLK = 1'b0;
  logic reset = 1'b1;

  run_controller_if bus ();

  run_controller #(.TIMEOUT(TMO)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;

  // Bench-driven controls
  logic       go_r = 1'b0;
  logic       halt_force = 1'b0;
  logic       halt_en = 1'b0;
  int         halt_at = 0;
  int         rdy_mode = 0;
  logic       load_en = 1'b0;
  logic       clr_stats = 1'b0;
  logic [7:0] core_vals [8];

  // Memory / core model state and observation statistics
  logic [7:0]  dm [256];
  logic [7:0]  rf [8];
  logic [10:0] beats [$];
  int   cyc = 0, run_cnt = 0, dump_cyc = 0;
  int   dm_we_cnt = 0, rf_we_cnt = 0, dm_err = 0, rf_err = 0, both_err = 0, hold_err = 0;
  int   last_rfwe_cyc = 0, start_low_cyc = 0;
  logic prev_hold = 1'b0;
  logic [2:0] prev_idx = '0;
  logic [7:0] prev_data = '0;
  logic rnd_bit = 1'b0;
  logic [7:0] rf5_snap = '0;

  int total = 0;
  int bad = 0;

  // Stub core raises halt once it has run halt_at cycles
  assign bus.go         = go_r;
  assign bus.halt       = halt_force || (halt_en && (run_cnt >= halt_at));
  assign bus.rf_rdata   = rf[bus.rf_addr];
  assign bus.dump_ready = (rdy_mode == 0) ? 1'b1 :
                          (rdy_mode == 1) ? ((dump_cyc % 3) == 2) : rnd_bit;

  // Memories, core register preset and observation counters
  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    rnd_bit <= ($urandom_range(0, 1) != 0);
    if (load_en) begin
      dm[17] <= 8'hAA;
      rf[5]  <= 8'h33;
    end
    if (bus.dm_we) dm[bus.dm_addr] <= bus.dm_wdata;
    if (bus.rf_we) rf[bus.rf_addr] <= bus.rf_wdata;
    if (clr_stats) begin
      run_cnt <= 0; dump_cyc <= 0; dm_we_cnt <= 0; rf_we_cnt <= 0;
      dm_err <= 0; rf_err <= 0; both_err <= 0; hold_err <= 0;
      prev_hold <= 1'b0; beats.delete();
    end else begin
      if (bus.dm_we && bus.rf_we) both_err <= both_err + 1;
      if (bus.dm_we) begin
        if (bus.dm_addr != 8'(dm_we_cnt)) dm_err <= dm_err + 1;
        dm_we_cnt <= dm_we_cnt + 1;
      end
      if (bus.rf_we) begin
        if (bus.rf_addr != 3'(rf_we_cnt)) rf_err <= rf_err + 1;
        rf_we_cnt     <= rf_we_cnt + 1;
        last_rfwe_cyc <= cyc;
      end
      if (!bus.start) begin
        if (run_cnt == 0) begin
          start_low_cyc <= cyc;
          rf5_snap      <= rf[5];
          for (int i = 0; i < 8; i++) rf[i] <= core_vals[i];
        end
        run_cnt <= run_cnt + 1;
      end
      if (bus.dump_valid) begin
        dump_cyc <= dump_cyc + 1;
        if (prev_hold && (bus.dump_idx != prev_idx || bus.dump_data != prev_data))
          hold_err <= hold_err + 1;
        if (bus.dump_ready) beats.push_back({bus.dump_idx, bus.dump_data});
        prev_hold <= !bus.dump_ready;
        prev_idx  <= bus.dump_idx;
        prev_data <= bus.dump_data;
      end else begin
        prev_hold <= 1'b0;
      end
    end
  end

  typedef struct {
    int     h;
    bit     hen;
    int     rmode;
    bit     go_mid;
    bit     hpulse;
    longint exp_cnt;
    bit     exp_to;
    int     exp_dcyc;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Run outcome from the rules: halt at or before the limit wins, otherwise the limit is hit
  function automatic void ref_run(input int h, input bit hen, output longint cnt, output bit to);
    if (hen && (h <= int'(TMO))) begin
      cnt = longint'(h);
      to  = 1'b0;
    end else begin
      cnt = longint'(TMO);
      to  = 1'b1;
    end
  endfunction

  task automatic do_run(input string tag, input vec_t v);
    for (int i = 0; i < 8; i++) core_vals[i] = 8'($urandom);
    halt_at  = v.h;
    halt_en  = v.hen;
    rdy_mode = v.rmode;
    @(negedge CLK); clr_stats = 1'b1;
    @(negedge CLK); clr_stats = 1'b0; go_r = 1'b1;
    @(negedge CLK); go_r = 1'b0;
    chk({tag, " busy after go"}, longint'(bus.busy), 1);
    if (v.hpulse) begin
      repeat (10) @(negedge CLK);
      halt_force = 1'b1;
      @(negedge CLK); halt_force = 1'b0;
      chk({tag, " still clearing after halt pulse"}, longint'(bus.dm_we && bus.busy), 1);
    end
    if (v.go_mid) begin
      for (int k = 0; k < 600 && bus.start; k++) @(negedge CLK);
      repeat (5) @(negedge CLK);
      go_r = 1'b1;
      @(negedge CLK); go_r = 1'b0;
    end
    for (int k = 0; k < 3000 && !bus.done; k++) @(negedge CLK);
    chk({tag, " done"}, longint'(bus.done), 1);
    chk({tag, " busy"}, longint'(bus.busy), 0);
    chk({tag, " start held"}, longint'(bus.start), 1);
    chk({tag, " dump_valid idle"}, longint'(bus.dump_valid), 0);
    chk({tag, " cycle_count"}, longint'(bus.cycle_count), v.exp_cnt);
    chk({tag, " timeout"}, longint'(bus.timeout), longint'(v.exp_to));
    chk({tag, " beat count"}, longint'(beats.size()), 8);
    for (int i = 0; i < 8 && i < beats.size(); i++)
      chk($sformatf("%s beat%0d idx/data", tag, i), longint'(beats[i]),
          longint'({3'(i), core_vals[i]}));
    if (v.exp_dcyc >= 0) chk({tag, " dump cycles"}, longint'(dump_cyc), longint'(v.exp_dcyc));
    chk({tag, " hold stable"}, longint'(hold_err), 0);
    chk({tag, " dm_we cycles"}, longint'(dm_we_cnt), 256);
    chk({tag, " dm addr order"}, longint'(dm_err), 0);
    chk({tag, " rf_we cycles"}, longint'(rf_we_cnt), 8);
    chk({tag, " rf addr order"}, longint'(rf_err), 0);
    chk({tag, " we exclusive"}, longint'(both_err), 0);
    // rf_we last seen high at edge F, start low first seen at F+3: start fell at F+2
    chk({tag, " launch gap"}, longint'(start_low_cyc - last_rfwe_cyc), 3);
  endtask

  initial begin
    vec_t v;
    longint ec;
    bit     et;

    //       h    hen  rm go_mid hpulse cnt  to   dcyc
    tbl[0] = '{40,  1'b1, 0, 1'b0, 1'b1, 40,  1'b0, 8};
    tbl[1] = '{40,  1'b1, 1, 1'b0, 1'b0, 40,  1'b0, 24};
    tbl[2] = '{0,   1'b0, 0, 1'b0, 1'b0, 100, 1'b1, 8};
    tbl[3] = '{100, 1'b1, 0, 1'b0, 1'b0, 100, 1'b0, 8};
    tbl[4] = '{101, 1'b1, 0, 1'b0, 1'b0, 100, 1'b1, 8};
    tbl[5] = '{0,   1'b1, 0, 1'b0, 1'b0, 0,   1'b0, 8};
    tbl[6] = '{60,  1'b1, 1, 1'b1, 1'b0, 60,  1'b0, 24};

    // Reset state
    @(negedge CLK);
    chk("reset start", longint'(bus.start), 1);
    chk("reset busy", longint'(bus.busy), 0);
    chk("reset done", longint'(bus.done), 0);
    chk("reset dm_we", longint'(bus.dm_we), 0);
    chk("reset rf_we", longint'(bus.rf_we), 0);
    chk("reset dump_valid", longint'(bus.dump_valid), 0);
    chk("reset cycle_count", longint'(bus.cycle_count), 0);
    chk("reset timeout", longint'(bus.timeout), 0);
    reset = 1'b0;

    // Preload values that the clear sequence must wipe
    @(negedge CLK); load_en = 1'b1;
    @(negedge CLK); load_en = 1'b0;

    for (int r = 0; r < 7; r++) begin
      do_run($sformatf("row%0d", r), tbl[r]);
      if (r == 0) begin
        chk("dm[17] cleared", longint'(dm[17]), 0);
        chk("r5 cleared before launch", longint'(rf5_snap), 0);
      end
    end

    // Randomized runs against the outcome model
    for (int n = 0; n < 8; n++) begin
      v.h      = int'($urandom_range(0, 130));
      v.hen    = ($urandom_range(0, 4) != 0);
      v.rmode  = 2;
      v.go_mid = 1'b0;
      v.hpulse = 1'b0;
      ref_run(v.h, v.hen, ec, et);
      v.exp_cnt  = ec;
      v.exp_to   = et;
      v.exp_dcyc = -1;
      do_run($sformatf("rnd%0d", n), v);
    end

    // Reset in the middle of a run
    halt_en = 1'b0;
    @(negedge CLK); clr_stats = 1'b1;
    @(negedge CLK); clr_stats = 1'b0; go_r = 1'b1;
    @(negedge CLK); go_r = 1'b0;
    for (int k = 0; k < 600 && bus.cycle_count != 20; k++) @(negedge CLK);
    chk("midrun reached 20", longint'(bus.cycle_count), 20);
    #2 reset = 1'b1;
    #1;
    chk("async reset start", longint'(bus.start), 1);
    chk("async reset cycle_count", longint'(bus.cycle_count), 0);
    chk("async reset busy", longint'(bus.busy), 0);
    chk("async reset done", longint'(bus.done), 0);
    @(negedge CLK); reset = 1'b0;
    do_run("after_reset", tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Synthesizable host-side controller for the core's start/halt launch interface; drives the opposite end of that interface from the core.
- On a go request it clears data memory and the register file through their write ports, holds then releases `start`, and counts cycles until `halt`.
- After halt or timeout it streams the register file out over a valid/ready port.
- Sits between the host/FPGA wrapper and TopLevel. It replaces the bench-only initialisation and readout with hardware.

Parameters:
- DM_DEPTH, 256: data memory words to clear; address width 8.
- RF_DEPTH, 8: registers to clear and dump; index width 3.
- START_CYCLES, 2: cycles `start` stays high after clearing, before release.
- TIMEOUT, 1000000: run-cycle limit; 0 disables the timeout.
- CNT_W, 32: width of cycle_count.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  launch request; sampled only in IDLE or DONE.
- start  out  1  core start/hold; 1 holds the core, 0 lets it run.
- halt  in  1  core done flag.
- dm_we  out  1  data memory write enable.
- dm_addr  out  8  data memory address.
- dm_wdata  out  8  data memory write data; always 0.
- rf_we  out  1  register file write enable.
- rf_addr  out  3  register file write/read address.
- rf_wdata  out  8  register file write data; always 0.
- rf_rdata  in  8  register file combinational read of rf_addr.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  host accepts the dump beat.
- dump_idx  out  3  register index of the current beat.
- dump_data  out  8  register value of the current beat (equals rf_rdata).
- cycle_count  out  CNT_W  count of run cycles.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- timeout  out  1  sticky until the next go; set if the run hit TIMEOUT.

Behaviour:
- Reset (async, any state): state=IDLE; start=1; all other outputs 0; counters 0.
- IDLE: start=1. go=1 at an edge → CLEAR_MEM next cycle; cycle_count, timeout and index counter are cleared on that edge.
- CLEAR_MEM: dm_we=1, dm_addr=0..DM_DEPTH-1, one word per cycle, exactly DM_DEPTH cycles → CLEAR_REG.
- CLEAR_REG: rf_we=1, rf_addr=0..RF_DEPTH-1, exactly RF_DEPTH cycles → LAUNCH.
- LAUNCH: start=1 and no writes for START_CYCLES cycles → RUN.
- RUN:
  - start=0; cycle_count increments by 1 on every RUN-state edge without halt.
  - halt=1 at an edge → DUMP; cycle_count is not incremented on that edge.
  - If TIMEOUT≠0 and cycle_count==TIMEOUT with halt=0 → timeout=1, then DUMP.
  - halt and timeout on the same edge: halt wins, timeout stays 0.
  - cycle_count saturates at all-ones and never wraps.
- DUMP:
  - start=1 from the first DUMP cycle onward (core re-held).
  - rf_we=0; rf_addr=dump_idx; dump_valid=1; dump_data=rf_rdata.
  - dump_idx advances only on dump_valid&&dump_ready.
  - While ready=0, dump_idx and dump_data hold stable.
  - Acceptance of index RF_DEPTH-1 → DONE.
- DONE: done=1, start=1, dump_valid=0. cycle_count and timeout hold. go=1 → CLEAR_MEM as from IDLE.
- go is ignored while busy. dm_we and rf_we are never both high.
- halt is ignored outside RUN.
- Reset mid-operation aborts immediately. A partial memory clear is acceptable; start=1 at once.

Test Plan:
- Clear sequence:
  - Stimulus: reset, then go pulse; preload dm[17]=8'hAA and r5=8'h33.
  - Required: dm_we high exactly 256 cycles covering addresses 0..255; rf_we high exactly 8 cycles; afterwards dm[17]=0 and r5=0; start falls exactly 2 cycles after rf_we falls.
- Normal run:
  - Stimulus: stub core raises halt 40 cycles after start falls, with registers preset to r0..r7 = 1..8.
  - Required: cycle_count=40; timeout=0; dump beats (idx, data) = (0,1)..(7,8); done=1.
- Backpressure:
  - Stimulus: dump_ready toggles 0,0,1 repeatedly.
  - Required: 8 beats, each held stable while ready=0, in order; 24 DUMP cycles total.
- Timeout:
  - Stimulus: TIMEOUT=100, halt never asserted.
  - Required: timeout=1; cycle_count=100; full dump still occurs; done=1.
- Boundary:
  - Stimulus: halt rises on the same edge cycle_count reaches TIMEOUT.
  - Required: timeout=0.
  - Stimulus: halt pulses while in CLEAR_MEM.
  - Required: ignored, no state change.
  - Stimulus: go pulses while busy.
  - Required: ignored.
- Reset mid-run:
  - Stimulus: assert reset during RUN at cycle_count=20.
  - Required: state returns to IDLE asynchronously; start=1; cycle_count=0; a subsequent go completes a full sequence normally.
